axi_dc_token_rx: RTL and testbench
==================================

# axi_dc_token_rx

Read-side endpoint of one token-ring clock-domain-crossing channel. It runs in the consumer clock domain and tracks which buffer slots the producer has filled, using a synchronized per-slot toggle vector. It steers the producer-side output mux with a one-hot read pointer and registers each word into a valid/ready output stage. One instance serves each channel that arrives from the far domain: AW/AR/W on the master side of the dual-clock AXI slice, R/B on the slave side.

## Interface

- DATA_WIDTH, 64: width of one channel word (packed AXI fields).
- BUFFER_WIDTH, 8: number of producer buffer slots; width of all token and pointer vectors; ≥2.
- SYNC_STAGES, 2: synchronizer flops on write_token_i; ≥2.
- clk_i  in  1  consumer-domain clock; the block uses this single clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- write_token_i  in  BUFFER_WIDTH  producer toggle vector; bit i toggles once per write of slot i; asynchronous to clk_i.
- data_async_i  in  DATA_WIDTH  producer buffer word at slot read_pointer_o; combinational through the producer mux.
- read_pointer_o  out  BUFFER_WIDTH  one-hot select of the next slot to consume.
- read_token_o  out  BUFFER_WIDTH  consumer toggle vector; bit i toggles once per consumption of slot i; the producer synchronizes it for free-slot accounting.
- valid_o  out  1  output word valid.
- ready_i  in  1  downstream accepts the word.
- data_o  out  DATA_WIDTH  registered output word.
- fill_o  out  $clog2(BUFFER_WIDTH+1)  slots pending in the producer buffer, excluding the output register.

## Operation

- Reset values: read_pointer_o = 1 (bit 0 set), read_token_o = 0, valid_o = 0, data_o = 0, fill_o = 0. All synchronizer flops reset to 0.
- wt_sync is write_token_i after SYNC_STAGES flops. Each bit is synchronized independently. This is legal because a producer write changes exactly one bit.
- pending = wt_sync XOR read_token_o.
- fill_o = popcount(pending), registered.
- slot_avail = |(pending AND read_pointer_o).
- Output stage has two states:
  - EMPTY (valid_o = 0).
  - FULL (valid_o = 1).
- load = slot_avail AND (EMPTY OR ready_i).
- On load:
  - data_o <= data_async_i.
  - valid_o <= 1.
  - read_token_o bit at the pointer position toggles.
  - read_pointer_o rotates left by one; bit BUFFER_WIDTH-1 wraps to bit 0.
- FULL AND ready_i AND NOT slot_avail: valid_o <= 0. data_o keeps its value.
- FULL AND NOT ready_i: data_o, valid_o, pointer and token all hold. This matches AXI stability rules.
- ready_i while EMPTY has no effect.
- Order is strictly by slot index, so words leave in producer write order.
- Full buffer (fill_o = BUFFER_WIDTH) is legal. Overrun prevention is the producer's job, via read_token_o.
- Reset mid-operation:
  - All state clears immediately, asynchronously; in-flight words are discarded.
  - The producer side must be reset in the same event. Toggle vectors re-align only when both sides are at 0.

## Timing

- Producer toggle to valid_o rising: SYNC_STAGES + 1 clk_i edges, with the output stage EMPTY.
- Throughput: one word per cycle while slot_avail and ready_i are held high, with no bubbles.
- Simultaneous handshake and new token arrival: the next word loads in the same cycle as the handshake.
- read_pointer_o → producer mux → data_async_i → data_o is a cross-domain combinational path. It needs a max-delay constraint of one clk_i period. Data is stable because the slot was written SYNC_STAGES cycles before being flagged.
- read_token_o must come straight from flops, with no logic between flop and port.
- fill_o lags wt_sync by one cycle.

## Structure

- Shared package axi_dc_pkg holds:
  - the default SYNC_STAGES constant;
  - a one-hot rotate-left function;
  - a popcount function sized by BUFFER_WIDTH.
- The same package is reused by the producer endpoint.
- Sub-module dc_sync_vec: a vector of SYNC_STAGES-deep flop synchronizers with async active-low reset. Instanced once for write_token_i.

## Test plan

- Reset: hold rst_ni = 0, drive random write_token_i → read_pointer_o = 0x01, read_token_o = 0x00, valid_o = 0, data_o = 0, fill_o = 0.
- Single word: BUFFER_WIDTH = 8, SYNC_STAGES = 2, ready_i = 1; producer writes 0xA5A5_0001 to slot 0 and toggles bit 0 → valid_o = 1 three edges later for one cycle, data_o = 0xA5A5_0001, then read_pointer_o = 0x02, read_token_o = 0x01.
- Backpressure: ready_i = 0, producer fills slots 0..7 with 0x10..0x17 → data_o = 0x10 held, fill_o = 7. Then raise ready_i → eight consecutive beats 0x10..0x17 with valid_o continuously high.
- Wrap: stream 20 words 0..19 with ready_i = 1 → output order 0..19, read_pointer_o passes 0x80 → 0x01 twice, final read_token_o = 0x0F.
- Random ready_i at 50% duty with random producer rate → no loss, duplication or reorder; data_o never changes while valid_o AND NOT ready_i.
- Async reset asserted mid-burst, without a clock edge → all outputs return to reset values immediately. After release, both sides restart at slot 0.

Source files
------------

// File: rtl/axi_dc_pkg.sv
// Shared helpers for the dual-clock token-ring channel endpoints (producer and consumer side).
package axi_dc_pkg;

  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned MAX_WIDTH           = 64;
  localparam int unsigned CNT_WIDTH           = 7;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Rotate the lowest 'width' bits of a one-hot vector left, wrapping the top bit to bit 0.
  function automatic logic [MAX_WIDTH-1:0] onehot_rotl(input logic [MAX_WIDTH-1:0] vec,
                                                       input int unsigned width);
    logic [MAX_WIDTH-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        if (i + 1 == width) res[0] = vec[i];
        else                res[(i + 1) % MAX_WIDTH] = vec[i];
      end
    end
    return res;
  endfunction

  // Number of set bits among the lowest 'width' bits.
  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [MAX_WIDTH-1:0] vec,
                                                    input int unsigned width);
    logic [CNT_WIDTH-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) cnt = cnt + CNT_WIDTH'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/dc_sync_vec.sv
// Per-bit multi-flop synchronizer; each bit crosses independently.
module dc_sync_vec #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/axi_dc_token_rx.sv
// Consumer-side endpoint of a token-ring CDC channel: tracks filled slots via toggle tokens
// and presents words in slot order through a registered valid/ready stage.
module axi_dc_token_rx
  import axi_dc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned BUFFER_WIDTH = 8,
  parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEFAULT,
  localparam int unsigned FILL_WIDTH  = $clog2(BUFFER_WIDTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [BUFFER_WIDTH-1:0] write_token_i,
  input  logic [DATA_WIDTH-1:0]   data_async_i,
  output logic [BUFFER_WIDTH-1:0] read_pointer_o,
  output logic [BUFFER_WIDTH-1:0] read_token_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [FILL_WIDTH-1:0]   fill_o
);

  logic [BUFFER_WIDTH-1:0] wt_sync;
  logic [BUFFER_WIDTH-1:0] pending;
  logic                    slot_avail;
  logic                    load;
  out_state_e              state_q;

  dc_sync_vec #(
    .WIDTH  (BUFFER_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_wt_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (write_token_i),
    .q_o    (wt_sync)
  );

  // A slot holds an unconsumed word while its producer and consumer tokens differ.
  assign pending    = wt_sync ^ read_token_o;
  assign slot_avail = |(pending & read_pointer_o);
  assign load       = slot_avail && ((state_q == EMPTY) || ready_i);
  assign valid_o    = (state_q == FULL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= EMPTY;
      data_o         <= '0;
      read_pointer_o <= BUFFER_WIDTH'(1);
      read_token_o   <= '0;
      fill_o         <= '0;
    end else begin
      fill_o <= FILL_WIDTH'(popcount(MAX_WIDTH'(pending), BUFFER_WIDTH));
      if (load) begin
        state_q        <= FULL;
        data_o         <= data_async_i;
        read_token_o   <= read_token_o ^ read_pointer_o;
        read_pointer_o <= BUFFER_WIDTH'(onehot_rotl(MAX_WIDTH'(read_pointer_o), BUFFER_WIDTH));
      end else if ((state_q == FULL) && ready_i) begin
        state_q <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_axi_dc_token_rx.sv
// Directed and randomized-rate bench for axi_dc_token_rx with a behavioural producer buffer.
module tb_axi_dc_token_rx;

  localparam int unsigned DW = 64;
  localparam int unsigned BW = 8;
  localparam int unsigned FW = $clog2(BW + 1);

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [BW-1:0] wt = '0;
  logic [DW-1:0] data_async;
  logic [BW-1:0] rd_ptr;
  logic [BW-1:0] rd_tok;
  logic          valid;
  logic          ready = 1'b0;
  logic [DW-1:0] data;
  logic [FW-1:0] fill;

  logic [DW-1:0] mem [BW];
  int unsigned   wp = 0;
  int            n_cmp = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  axi_dc_token_rx #(.DATA_WIDTH(DW), .BUFFER_WIDTH(BW), .SYNC_STAGES(2)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .write_token_i  (wt),
    .data_async_i   (data_async),
    .read_pointer_o (rd_ptr),
    .read_token_o   (rd_tok),
    .valid_o        (valid),
    .ready_i        (ready),
    .data_o         (data),
    .fill_o         (fill)
  );

  // Producer output mux steered by the one-hot read pointer.
  always_comb begin
    data_async = '0;
    for (int i = 0; i < BW; i++) if (rd_ptr[i]) data_async = mem[i];
  end

  task automatic prod_write(input logic [DW-1:0] d);
    mem[wp] = d;
    wt[wp]  = ~wt[wp];
    wp      = (wp + 1) % BW;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    ready  = 1'b0;
    wt     = '0;
    wp     = 0;
    for (int i = 0; i < BW; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    n_cmp++;
    if (rd_ptr !== 8'h01 || rd_tok !== 8'h00 || valid !== 1'b0 || data !== '0 || fill !== '0) begin
      n_fail++;
      $display("FAIL %s: ptr=%h tok=%h valid=%b data=%h fill=%0d, required ptr=01 tok=00 valid=0 data=0 fill=0",
               tag, rd_ptr, rd_tok, valid, data, fill);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wt = BW'($urandom);
      @(negedge clk);
      check_reset_vals("reset_hold");
    end
    wt = '0;
  endtask

  task automatic test_single();
    do_reset();
    ready = 1'b1;
    prod_write(64'hA5A5_0001);
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      n_cmp++;
      if (valid !== (e == 3)) begin
        n_fail++;
        $display("FAIL single_valid_edge%0d: got %b, required %b", e, valid, (e == 3));
      end
    end
    n_cmp++;
    if (data !== 64'hA5A5_0001 || rd_ptr !== 8'h02 || rd_tok !== 8'h01) begin
      n_fail++;
      $display("FAIL single_word: data=%h ptr=%h tok=%h, required data=a5a50001 ptr=02 tok=01",
               data, rd_ptr, rd_tok);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      prod_write(DW'(8'h10 + i));
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (valid !== 1'b1 || data !== 64'h10 || fill !== FW'(7)) begin
      n_fail++;
      $display("FAIL bp_hold: valid=%b data=%h fill=%0d, required valid=1 data=10 fill=7", valid, data, fill);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (valid !== 1'b1 || data !== DW'(8'h10 + k)) begin
        n_fail++;
        $display("FAIL bp_beat%0d: valid=%b data=%h, required valid=1 data=%h", k, valid, data, 8'h10 + k);
      end
      ready = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (valid !== 1'b0 || fill !== '0) begin
      n_fail++;
      $display("FAIL bp_drained: valid=%b fill=%0d, required valid=0 fill=0", valid, fill);
    end
  endtask

  task automatic test_wrap();
    int unsigned nw = 0;
    int unsigned exp = 0;
    int unsigned wraps = 0;
    logic [BW-1:0] prev_ptr;
    do_reset();
    ready = 1'b1;
    prev_ptr = rd_ptr;
    for (int c = 0; c < 60; c++) begin
      if (prev_ptr == 8'h80 && rd_ptr == 8'h01) wraps++;
      prev_ptr = rd_ptr;
      if (valid) begin
        n_cmp++;
        if (data !== DW'(exp)) begin
          n_fail++;
          $display("FAIL wrap_order: got %h, required %h", data, exp);
        end
        exp++;
      end
      if (nw < 20) begin
        prod_write(DW'(nw));
        nw++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (exp != 20 || wraps != 2 || rd_tok !== 8'h0F || rd_ptr !== 8'h10) begin
      n_fail++;
      $display("FAIL wrap_final: words=%0d wraps=%0d tok=%h ptr=%h, required words=20 wraps=2 tok=0f ptr=10",
               exp, wraps, rd_tok, rd_ptr);
    end
  endtask

  task automatic test_random();
    int unsigned nw = 0;
    int unsigned nr = 0;
    logic          hold = 1'b0;
    logic [DW-1:0] hold_data = '0;
    do_reset();
    for (int c = 0; c < 3000 && nr < 200; c++) begin
      if (hold) begin
        n_cmp++;
        if (valid !== 1'b1 || data !== hold_data) begin
          n_fail++;
          $display("FAIL rand_stable: valid=%b data=%h, required valid=1 data=%h", valid, data, hold_data);
        end
      end
      ready = 1'($urandom_range(0, 1));
      hold  = 1'b0;
      if (valid) begin
        if (ready) begin
          n_cmp++;
          if (data !== (64'hC000_0000 + DW'(nr))) begin
            n_fail++;
            $display("FAIL rand_order: got %h, required %h", data, 64'hC000_0000 + DW'(nr));
          end
          nr++;
        end else begin
          hold      = 1'b1;
          hold_data = data;
        end
      end
      if (nw < 200 && (nw - nr) < 7 && $urandom_range(0, 1) == 1) begin
        prod_write(64'hC000_0000 + DW'(nw));
        nw++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (nr != 200) begin
      n_fail++;
      $display("FAIL rand_count: received %0d, required 200", nr);
    end
  endtask

  task automatic test_async_reset();
    int unsigned waited = 0;
    do_reset();
    for (int i = 0; i < 3; i++) prod_write(DW'(32'h77 + i));
    repeat (6) @(negedge clk);
    n_cmp++;
    if (valid !== 1'b1 || data !== 64'h77 || rd_ptr !== 8'h02) begin
      n_fail++;
      $display("FAIL areset_pre: valid=%b data=%h ptr=%h, required valid=1 data=77 ptr=02", valid, data, rd_ptr);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_vals("areset_immediate");
    wt = '0;
    wp = 0;
    @(negedge clk);
    rst_ni = 1'b1;
    ready  = 1'b1;
    @(negedge clk);
    prod_write(64'h55);
    while (!valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (valid !== 1'b1 || data !== 64'h55 || rd_ptr !== 8'h02 || rd_tok !== 8'h01 || waited != 3) begin
      n_fail++;
      $display("FAIL areset_restart: valid=%b data=%h ptr=%h tok=%h edges=%0d, required valid=1 data=55 ptr=02 tok=01 edges=3",
               valid, data, rd_ptr, rd_tok, waited);
    end
  endtask

  initial begin
    for (int i = 0; i < BW; i++) mem[i] = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
